aes_pipe_scheduler: RTL and testbench



---
 rtl/aes_pipe_scheduler_if.sv | 35 +++
 rtl/aes_pipe_scheduler.sv | 153 +++++++++++++++
 tb/tb_aes_pipe_scheduler.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pipe_scheduler_if.sv
// Requester and response bundle for the AES pipe scheduler.
//
// Handshake rules (both directions):
//  - A transfer happens on a rising clk edge where valid and ready are both 1.
//  - Requesters hold req_pt/req_key stable while req_valid is 1 and not yet
//    accepted. They may drop req_valid without a transfer.
//  - req_ready is one-hot or zero. It may rise only for a requester that is
//    presenting req_valid.
//  - rsp_valid stays high until a transfer. rsp_data/rsp_id stay stable
//    until that transfer.
interface aes_pipe_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_pt;
  logic [NREQ*128-1:0] req_key;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [127:0]        rsp_data;
  logic [IDW-1:0]      rsp_id;

  // Requester and consumer side.
  modport master (
    output req_valid, req_pt, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_pt, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/aes_pipe_scheduler.sv
// Shares one non-stalling, fixed-latency AES-128 core among NREQ requesters.
//
// Arbitration is round-robin. A tag pipe tracks each block's owner alongside
// the core. Admission is credit based: fifo_count + inflight never exceeds
// FIFO_DEPTH. Because of that, every block that leaves the core has a free
// FIFO slot, even when the consumer stalls.
module aes_pipe_scheduler #(
  parameter int NREQ       = 4,
  parameter int LAT        = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  aes_pipe_scheduler_if.slave      bus,
  output logic [127:0]             aes_p,
  output logic [127:0]             aes_k,
  input  logic [127:0]             aes_c,
  output logic [$clog2(LAT+1)-1:0] inflight
);

  localparam int IFW  = $clog2(LAT + 1);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  logic [IDW-1:0]  rr_last;
  logic [CNTW-1:0] fifo_count;
  logic [31:0]     occupancy;
  logic            issue_ok;
  logic            any_req;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  cand;
  int unsigned     rr_sum;
  logic            issue;
  logic            capture;
  logic            pop;

  logic [LAT-1:0]  tag_v;
  logic [IDW-1:0]  tag_id [LAT];

  logic [127:0]    mem_data [FIFO_DEPTH];
  logic [IDW-1:0]  mem_id   [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Credit: blocks still owed to the FIFO (in the core or stored) must leave room.
  always_comb begin
    occupancy = 32'(fifo_count) + 32'(inflight);
    issue_ok  = !rst && (occupancy < 32'(FIFO_DEPTH));
  end

  // Round-robin search that starts just after the last winner.
  always_comb begin
    any_req = 1'b0;
    grant   = '0;
    cand    = '0;
    rr_sum  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_sum = 32'(rr_last) + 32'(k);
      if (rr_sum >= 32'(NREQ)) rr_sum = rr_sum - 32'(NREQ);
      cand = IDW'(rr_sum);
      if (!any_req && bus.req_valid[cand]) begin
        any_req = 1'b1;
        grant   = cand;
      end
    end
  end

  // Only the winner sees ready. A bubble drives zeros into the core.
  always_comb begin
    issue         = issue_ok && any_req;
    bus.req_ready = '0;
    aes_p         = '0;
    aes_k         = '0;
    if (issue) begin
      bus.req_ready[grant] = 1'b1;
      aes_p = bus.req_pt[{grant, 7'd0} +: 128];
      aes_k = bus.req_key[{grant, 7'd0} +: 128];
    end
  end

  // The priority pointer moves to the winner only when a block actually issues.
  always_ff @(posedge clk) begin
    if (rst)        rr_last <= IDW'(NREQ - 1);
    else if (issue) rr_last <= grant;
  end

  // Tag pipe. The last stage lines up with the cycle the core presents aes_c.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= issue;
      for (int i = 1; i < LAT; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  // Tag ids need no reset; they only matter when the valid bit is set.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant;
    for (int i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
  end

  assign capture = tag_v[LAT-1];

  // Count of valid tags. Issue and capture in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({issue, capture})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign bus.rsp_valid = (fifo_count != '0);
  assign bus.rsp_data  = mem_data[rd_ptr];
  assign bus.rsp_id    = mem_id[rd_ptr];
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  // Storage writes. Credit guarantees a free slot whenever capture is set.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_data[wr_ptr] <= aes_c;
      mem_id[wr_ptr]   <= tag_id[LAT-1];
    end
  end

  // FIFO pointers and count. Reset discards everything that was stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (capture) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Bench for aes_pipe_scheduler: behavioural AES core, scoreboard, scenarios.
module tb_aes_pipe_scheduler;
  localparam int NREQ = 4, LAT = 10, FIFO_DEPTH = 16, IDW = 2;
  localparam int IFW = $clog2(LAT + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_pipe_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus();
  logic [127:0] aes_p, aes_k, aes_c;
  logic [IFW-1:0] inflight;

  aes_pipe_scheduler #(.NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .aes_p(aes_p), .aes_k(aes_k), .aes_c(aes_c), .inflight(inflight)
  );

  logic [127:0] pt_r [NREQ];
  logic [127:0] key_r [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign bus.req_pt[128*gi +: 128]  = pt_r[gi];
    assign bus.req_key[128*gi +: 128] = key_r[gi];
  end

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x, y;
    r = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc;
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[q+4*c] = t[q + 4*((c+q)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // Behavioural core: fixed LAT-cycle pipe, sampled mid-cycle.
  logic [127:0] core_in;
  logic [127:0] core_pipe [LAT];
  always @(negedge clk) core_in = aes_enc(aes_p, aes_k);
  always @(posedge clk) begin
    core_pipe[0] <= core_in;
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign aes_c = core_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [127:0]   ct;
    logic [31:0]    t;
  } ent_t;
  ent_t exp_q[$];
  int rsp_id_log[$];
  int rsp_cyc_log[$];
  int n_checks = 0, n_pass = 0;
  int n_issue = 0, n_pop = 0, max_out = 0;
  bit mon_en = 1'b0;
  int m_rr = NREQ - 1;
  int m_g, m_j, m_if, m_d;
  bit m_found, m_rv;
  logic [NREQ-1:0] m_ready, last_acc;
  logic [127:0] m_p, m_k;

  // Model: outstanding blocks in issue order. A block is in the core for
  // cycles t+1..t+LAT and visible from t+LAT+1.
  always @(negedge clk) begin
    if (mon_en) begin
      m_found = 1'b0; m_g = 0;
      if (!rst && exp_q.size() < FIFO_DEPTH) begin
        for (int k = 1; k <= NREQ; k++) begin
          m_j = (m_rr + k) % NREQ;
          if (!m_found && bus.req_valid[m_j]) begin m_found = 1'b1; m_g = m_j; end
        end
      end
      m_ready = m_found ? (NREQ'(1) << m_g) : '0;
      m_p = m_found ? pt_r[m_g] : 128'h0;
      m_k = m_found ? key_r[m_g] : 128'h0;
      m_if = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        m_d = cyc - int'(exp_q[i].t);
        if (m_d >= 1 && m_d <= LAT) m_if++;
      end
      m_rv = (exp_q.size() > 0) && (cyc - int'(exp_q[0].t) >= LAT + 1);

      n_checks++;
      if (bus.req_ready !== m_ready) $display("FAIL sb_req_ready cyc=%0d got %b want %b", cyc, bus.req_ready, m_ready);
      else n_pass++;
      n_checks++;
      if (aes_p !== m_p || aes_k !== m_k) $display("FAIL sb_aes_in cyc=%0d got p=%h want p=%h", cyc, aes_p, m_p);
      else n_pass++;
      n_checks++;
      if (inflight !== IFW'(m_if)) $display("FAIL sb_inflight cyc=%0d got %0d want %0d", cyc, inflight, m_if);
      else n_pass++;
      n_checks++;
      if (bus.rsp_valid !== m_rv) $display("FAIL sb_rsp_valid cyc=%0d got %b want %b", cyc, bus.rsp_valid, m_rv);
      else n_pass++;
      if (m_rv) begin
        n_checks++;
        if (bus.rsp_data !== exp_q[0].ct || bus.rsp_id !== exp_q[0].id)
          $display("FAIL sb_rsp cyc=%0d got %h/id%0d want %h/id%0d", cyc, bus.rsp_data, bus.rsp_id, exp_q[0].ct, exp_q[0].id);
        else n_pass++;
      end

      last_acc = bus.req_valid & bus.req_ready;
      if (m_rv && bus.rsp_ready) begin
        rsp_id_log.push_back(int'(exp_q[0].id));
        rsp_cyc_log.push_back(cyc);
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (m_found) begin
        exp_q.push_back('{id: IDW'(m_g), ct: aes_enc(m_p, m_k), t: 32'(cyc)});
        m_rr = m_g;
        n_issue++;
      end
      if (exp_q.size() > max_out) max_out = exp_q.size();
      if (rst) begin
        exp_q.delete();
        m_rr = NREQ - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (cyc > 20000) begin
      $display("FAIL watchdog cyc=%0d limit 20000", cyc);
      $fatal(1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic new_data(input int i);
    pt_r[i]  = {$urandom, $urandom, $urandom, $urandom};
    key_r[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Advance a cycle and give every requester accepted last cycle a new block.
  task automatic step();
    tick();
    for (int i = 0; i < NREQ; i++) if (last_acc[i]) new_data(i);
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (n) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.req_valid = '1;
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0 || inflight !== '0)
      $display("FAIL reset_state got rv=%b rdy=%b if=%0d want 0/0/0", bus.rsp_valid, bus.req_ready, inflight);
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0)
      $display("FAIL reset_idle got rdy=%b rv=%b want 0/0", bus.req_ready, bus.rsp_valid);
    else n_pass++;
  endtask

  task automatic test_single();
    int t0, tr;
    bit found;
    logic [127:0] d;
    logic [IDW-1:0] id;
    tick();
    pt_r[2] = 128'h00112233445566778899aabbccddeeff;
    key_r[2] = 128'h000102030405060708090a0b0c0d0e0f;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    t0 = cyc;
    n_checks++;
    if (bus.req_ready !== 4'b0100) $display("FAIL single_grant got %b want 0100", bus.req_ready);
    else n_pass++;
    tick();
    bus.req_valid = '0;
    found = 1'b0; tr = 0; d = '0; id = '0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin found = 1'b1; tr = cyc; d = bus.rsp_data; id = bus.rsp_id; end
      else tick();
    end
    n_checks++;
    if (!found || tr != t0 + LAT + 1) $display("FAIL single_latency got found=%b dt=%0d want dt=%0d", found, tr - t0, LAT + 1);
    else n_pass++;
    n_checks++;
    if (d !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) $display("FAIL single_data got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", d);
    else n_pass++;
    n_checks++;
    if (id !== 2'd2 || aes_p !== 128'h0) $display("FAIL single_id_bubble got id=%0d p=%h want 2/0", id, aes_p);
    else n_pass++;
    drain(3);
  endtask

  task automatic test_round_robin();
    int gq[$];
    int g;
    do_reset();
    rsp_id_log.delete(); rsp_cyc_log.delete();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) new_data(i);
    bus.req_valid = '1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      g = -1;
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
      gq.push_back(g);
      step();
    end
    drain(20);
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (gq[k] != k % NREQ) $display("FAIL rr_grant k=%0d got %0d want %0d", k, gq[k], k % NREQ);
      else n_pass++;
    end
    n_checks++;
    if (rsp_id_log.size() != 24) $display("FAIL rr_rsp_count got %0d want 24", rsp_id_log.size());
    else n_pass++;
    for (int k = 0; k < rsp_id_log.size() && k < 24; k++) begin
      n_checks++;
      if (rsp_id_log[k] != k % NREQ || rsp_cyc_log[k] != rsp_cyc_log[0] + k)
        $display("FAIL rr_rsp k=%0d got id=%0d dc=%0d want id=%0d dc=%0d", k, rsp_id_log[k], rsp_cyc_log[k] - rsp_cyc_log[0], k % NREQ, k);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int n0, first_iss, first_rv, max_if;
    bus.rsp_ready = 1'b0;
    do_reset();
    rsp_id_log.delete(); rsp_cyc_log.delete();
    n0 = n_issue; first_iss = -1; first_rv = -1; max_if = 0;
    for (int i = 0; i < NREQ; i++) new_data(i);
    bus.req_valid = '1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (first_iss < 0 && bus.req_ready != '0) first_iss = cyc;
      if (first_rv < 0 && bus.rsp_valid) first_rv = cyc;
      if (int'(inflight) > max_if) max_if = int'(inflight);
      step();
    end
    @(negedge clk);
    n_checks++;
    if (n_issue - n0 != FIFO_DEPTH || bus.req_ready !== '0)
      $display("FAIL bp_issue_count got %0d rdy=%b want %0d/0", n_issue - n0, bus.req_ready, FIFO_DEPTH);
    else n_pass++;
    n_checks++;
    if (max_if != LAT) $display("FAIL bp_inflight_peak got %0d want %0d", max_if, LAT);
    else n_pass++;
    n_checks++;
    if (first_iss < 0 || first_rv - first_iss != LAT + 1) $display("FAIL bp_first_rsp got dt=%0d want %0d", first_rv - first_iss, LAT + 1);
    else n_pass++;
    step();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 40; k++) step();
    n_checks++;
    if (n_issue - n0 <= FIFO_DEPTH) $display("FAIL bp_resume got %0d issues want more than %0d", n_issue - n0, FIFO_DEPTH);
    else n_pass++;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      n_checks++;
      if (k >= rsp_id_log.size() || rsp_id_log[k] != k % NREQ)
        $display("FAIL bp_drain_order k=%0d got %0d want %0d", k, (k < rsp_id_log.size()) ? rsp_id_log[k] : -1, k % NREQ);
      else n_pass++;
    end
    drain(30);
  endtask

  task automatic test_full_push_pop();
    int i0, p0, n_if10;
    bus.rsp_ready = 1'b0;
    do_reset();
    for (int i = 0; i < NREQ; i++) new_data(i);
    bus.req_valid = '1;
    for (int k = 0; k < 32; k++) step();
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.req_ready !== '0 || inflight !== '0)
      $display("FAIL full_state got rv=%b rdy=%b if=%0d want 1/0/0", bus.rsp_valid, bus.req_ready, inflight);
    else n_pass++;
    step();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) step();
    i0 = n_issue; p0 = n_pop; n_if10 = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (inflight == IFW'(LAT)) n_if10++;
      step();
    end
    n_checks++;
    if (n_issue - i0 != 30 || n_pop - p0 != 30)
      $display("FAIL full_throughput got iss=%0d pop=%0d want 30/30", n_issue - i0, n_pop - p0);
    else n_pass++;
    n_checks++;
    if (n_if10 != 30) $display("FAIL full_inflight_steady got %0d cycles want 30", n_if10);
    else n_pass++;
    drain(30);
  endtask

  task automatic test_reset_mid();
    int t0, n0, n_stale;
    bus.rsp_ready = 1'b0;
    do_reset();
    n0 = n_issue; t0 = 0;
    for (int i = 0; i < NREQ; i++) new_data(i);
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) t0 = cyc;
      step();
    end
    bus.req_valid = '0;
    while (cyc < t0 + 13 && cyc < t0 + 40) tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (n_issue - n0 != 8 || inflight !== IFW'(5) || bus.rsp_valid !== 1'b1)
      $display("FAIL mid_pre got iss=%0d if=%0d rv=%b want 8/5/1", n_issue - n0, inflight, bus.rsp_valid);
    else n_pass++;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || inflight !== '0)
      $display("FAIL mid_post got rv=%b if=%0d want 0/0", bus.rsp_valid, inflight);
    else n_pass++;
    n_stale = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      if (bus.rsp_valid) n_stale++;
    end
    n_checks++;
    if (n_stale != 0) $display("FAIL mid_stale got %0d cycles want 0", n_stale);
    else n_pass++;
    tick();
    bus.req_valid = '1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0001) $display("FAIL mid_fresh_grant got %b want 0001", bus.req_ready);
    else n_pass++;
    for (int k = 0; k < 4; k++) step();
    drain(20);
  endtask

  task automatic test_sparse();
    int iss[$];
    int mn, mx;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    do_reset();
    rsp_id_log.delete(); rsp_cyc_log.delete();
    mn = 99; mx = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      new_data(3);
      bus.req_valid = 4'b1000;
      @(negedge clk);
      iss.push_back(cyc);
      n_checks++;
      if (bus.req_ready !== 4'b1000 || aes_p !== pt_r[3]) $display("FAIL sparse_issue k=%0d got rdy=%b want 1000", k, bus.req_ready);
      else n_pass++;
      if (k >= 4) begin mn = (int'(inflight) < mn) ? int'(inflight) : mn; mx = (int'(inflight) > mx) ? int'(inflight) : mx; end
      for (int b = 0; b < 2; b++) begin
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (aes_p !== 128'h0) $display("FAIL sparse_bubble k=%0d got %h want 0", k, aes_p);
        else n_pass++;
        if (k >= 4) begin mn = (int'(inflight) < mn) ? int'(inflight) : mn; mx = (int'(inflight) > mx) ? int'(inflight) : mx; end
      end
    end
    drain(15);
    n_checks++;
    if (mn != 3 || mx != 4) $display("FAIL sparse_inflight got min=%0d max=%0d want 3/4", mn, mx);
    else n_pass++;
    n_checks++;
    if (rsp_cyc_log.size() != 12) $display("FAIL sparse_count got %0d want 12", rsp_cyc_log.size());
    else n_pass++;
    for (int k = 0; k < rsp_cyc_log.size() && k < 12; k++) begin
      n_checks++;
      if (rsp_cyc_log[k] != iss[k] + LAT + 1 || rsp_id_log[k] != 3)
        $display("FAIL sparse_rsp k=%0d got dt=%0d id=%0d want dt=%0d id=3", k, rsp_cyc_log[k] - iss[k], rsp_id_log[k], LAT + 1);
      else n_pass++;
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin pt_r[i] = '0; key_r[i] = '0; end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid();
    test_sparse();
    n_checks++;
    if (max_out != FIFO_DEPTH) $display("FAIL credit_bound got max outstanding %0d want %0d", max_out, FIFO_DEPTH);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
